// File: rtl/me_stage_vl.sv
// Memory-access stage between EX and WB: waits for variable-latency load data, buffers it while
// WB stalls, discards responses of flushed loads, and exposes forwarding/hazard info to ID.
module me_stage_vl #(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEST_W   = 5,
  parameter int unsigned MAX_DROP = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             EX_to_ME_Valid,
  input  logic [PC_W+DATA_W+DEST_W+6-1:0]  EX_to_ME_Bus,
  output logic                             ME_Allow_in,
  input  logic                             WB_Allow_in,
  output logic                             ME_to_WB_Valid,
  output logic [PC_W+DEST_W+1+DATA_W-1:0]  ME_to_WB_Bus,
  input  logic                             flush,
  input  logic                             data_sram_data_ok,
  input  logic [DATA_W-1:0]                data_sram_rdata,
  output logic [DEST_W-1:0]                ME_dest,
  output logic                             ME_fwd_valid,
  output logic [DATA_W-1:0]                ME_fwd_data
);

  localparam int unsigned OffW = $clog2(DATA_W / 8);
  localparam int unsigned CntW = $clog2(MAX_DROP + 1);

  logic [PC_W-1:0]   ex_pc;
  logic [DATA_W-1:0] ex_alu;
  logic [2:0]        ex_mem_op;
  logic              ex_res_mem;
  logic              ex_gr_we;
  logic [DEST_W-1:0] ex_dest;

  assign {ex_pc, ex_alu, ex_mem_op, ex_res_mem, ex_gr_we, ex_dest} = EX_to_ME_Bus;

  logic              me_valid_q, me_valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [2:0]        mem_op_q, mem_op_d;
  logic              res_mem_q, res_mem_d;
  logic              gr_we_q, gr_we_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic              rbuf_valid_q, rbuf_valid_d;
  logic [CntW-1:0]   drop_cnt_q, drop_cnt_d;

  logic              data_ok_live;
  logic              wait_data;
  logic              ready_go;
  logic              allow_in;
  logic              to_wb_valid;
  logic              leave;
  logic              accept;
  logic              drop_inc;
  logic              drop_dec;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] extracted;
  logic [DATA_W-1:0] final_result;

  // Handshake: a response only belongs to the current load once every stale one has drained.
  always_comb begin
    data_ok_live = data_sram_data_ok && (drop_cnt_q == '0);
    wait_data    = me_valid_q && res_mem_q && !rbuf_valid_q;
    ready_go     = !me_valid_q || !res_mem_q || rbuf_valid_q || data_ok_live;
    allow_in     = !me_valid_q || (ready_go && WB_Allow_in);
    to_wb_valid  = me_valid_q && ready_go && !flush;
    leave        = to_wb_valid && WB_Allow_in;
    accept       = EX_to_ME_Valid && allow_in;
    drop_inc     = flush && wait_data && !data_ok_live;
    drop_dec     = data_sram_data_ok && (drop_cnt_q != '0);
  end

  always_comb begin
    me_valid_d   = me_valid_q;
    pc_d         = pc_q;
    alu_d        = alu_q;
    mem_op_d     = mem_op_q;
    res_mem_d    = res_mem_q;
    gr_we_d      = gr_we_q;
    dest_d       = dest_q;
    rbuf_d       = rbuf_q;
    rbuf_valid_d = rbuf_valid_q;
    drop_cnt_d   = drop_cnt_q + CntW'(drop_inc) - CntW'(drop_dec);

    if (flush) begin
      me_valid_d = 1'b0;
    end else if (allow_in) begin
      me_valid_d = EX_to_ME_Valid;
    end

    if (accept) begin
      pc_d      = ex_pc;
      alu_d     = ex_alu;
      mem_op_d  = ex_mem_op;
      res_mem_d = ex_res_mem;
      gr_we_d   = ex_gr_we;
      dest_d    = ex_dest;
    end

    if (flush || leave) begin
      rbuf_valid_d = 1'b0;
    end else if (data_ok_live && wait_data && !WB_Allow_in) begin
      rbuf_valid_d = 1'b1;
      rbuf_d       = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      me_valid_q   <= 1'b0;
      pc_q         <= '0;
      alu_q        <= '0;
      mem_op_q     <= '0;
      res_mem_q    <= 1'b0;
      gr_we_q      <= 1'b0;
      dest_q       <= '0;
      rbuf_q       <= '0;
      rbuf_valid_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      me_valid_q   <= me_valid_d;
      pc_q         <= pc_d;
      alu_q        <= alu_d;
      mem_op_q     <= mem_op_d;
      res_mem_q    <= res_mem_d;
      gr_we_q      <= gr_we_d;
      dest_q       <= dest_d;
      rbuf_q       <= rbuf_d;
      rbuf_valid_q <= rbuf_valid_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Little-endian lane select: shift the addressed byte down to bit 0, then extend.
  always_comb begin
    raw     = rbuf_valid_q ? rbuf_q : data_sram_rdata;
    shifted = raw >> {alu_q[OffW-1:0], 3'b000};
    case (mem_op_q)
      3'd0:    extracted = DATA_W'($signed(shifted[7:0]));
      3'd1:    extracted = DATA_W'($signed(shifted[15:0]));
      3'd2:    extracted = DATA_W'($signed(shifted[31:0]));
      3'd4:    extracted = DATA_W'(shifted[7:0]);
      3'd5:    extracted = DATA_W'(shifted[15:0]);
      3'd6:    extracted = DATA_W'(shifted[31:0]);
      default: extracted = raw;
    endcase
    final_result = res_mem_q ? extracted : alu_q;
  end

  assign ME_Allow_in    = allow_in;
  assign ME_to_WB_Valid = to_wb_valid;
  assign ME_to_WB_Bus   = {pc_q, gr_we_q, dest_q, final_result};
  assign ME_dest        = (me_valid_q && gr_we_q) ? dest_q : '0;
  assign ME_fwd_valid   = me_valid_q && gr_we_q && ready_go;
  assign ME_fwd_data    = final_result;

  drop_cnt_sat_a: assert property (@(posedge clk) disable iff (reset)
    !(drop_inc && !drop_dec && (drop_cnt_q == CntW'(MAX_DROP))));

endmodule

// File: tb/tb_me_stage_vl.sv
// Self-checking bench for me_stage_vl: directed vectors, corner sequences and a randomized run
// against a transaction-level model of the stage and the load-response stream.
module tb_me_stage_vl;

  localparam int PC_W   = 32;
  localparam int DATA_W = 32;
  localparam int DEST_W = 5;
  localparam int BUS_W  = PC_W + DATA_W + DEST_W + 6;
  localparam int OUT_W  = PC_W + DEST_W + 1 + DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              ex_valid;
  logic [BUS_W-1:0]  ex_bus;
  logic              allow_in;
  logic              wb_allow;
  logic              wb_valid;
  logic [OUT_W-1:0]  wb_bus;
  logic              flush;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;
  logic [DEST_W-1:0] me_dest;
  logic              fwd_valid;
  logic [DATA_W-1:0] fwd_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  me_stage_vl #(
    .PC_W    (PC_W),
    .DATA_W  (DATA_W),
    .DEST_W  (DEST_W),
    .MAX_DROP(3)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .EX_to_ME_Valid   (ex_valid),
    .EX_to_ME_Bus     (ex_bus),
    .ME_Allow_in      (allow_in),
    .WB_Allow_in      (wb_allow),
    .ME_to_WB_Valid   (wb_valid),
    .ME_to_WB_Bus     (wb_bus),
    .flush            (flush),
    .data_sram_data_ok(data_ok),
    .data_sram_rdata  (rdata),
    .ME_dest          (me_dest),
    .ME_fwd_valid     (fwd_valid),
    .ME_fwd_data      (fwd_data)
  );

  logic [31:0] wb_pc;
  logic        wb_we;
  logic [4:0]  wb_dst;
  logic [31:0] wb_res;
  assign {wb_pc, wb_we, wb_dst, wb_res} = wb_bus;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BUS_W-1:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                          input logic [2:0] op, input logic rm, input logic we,
                                          input logic [4:0] dst);
    return {pc, alu, op, rm, we, dst};
  endfunction

  // Reference load extraction straight from the ISA description.
  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] off,
                                           input logic [2:0] op);
    logic [31:0] s;
    s = d >> (8 * off);
    case (op)
      3'd0:       return {{24{s[7]}}, s[7:0]};
      3'd1:       return {{16{s[15]}}, s[15:0]};
      3'd4:       return {24'h0, s[7:0]};
      3'd5:       return {16'h0, s[15:0]};
      3'd2, 3'd6: return s;
      default:    return d;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    ex_bus   = '0;
    flush    = 1'b0;
    data_ok  = 1'b0;
    wb_allow = 1'b1;
    rdata    = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  off;
    logic [2:0]  op;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] res;
    logic        ld;
    logic        got;
    int          id;
  } exp_t;

  typedef struct {
    int          id;
    logic [31:0] data;
  } rsp_t;

  vec_t tbl[12];
  exp_t mq[$];
  rsp_t pend[$];

  initial begin
    exp_t        e;
    rsp_t        r;
    logic        exp_ready, exp_valid, exp_allow, is_ld, we;
    logic [2:0]  op;
    logic [31:0] alu, ld_data, pc_ctr;
    logic [4:0]  dst;
    int          next_id;

    tbl[0]  = '{32'h80FF_7F01, 2'd1, 3'd0, 32'h0000_007F};
    tbl[1]  = '{32'h80FF_7F01, 2'd1, 3'd4, 32'h0000_007F};
    tbl[2]  = '{32'h80FF_7F01, 2'd2, 3'd1, 32'hFFFF_80FF};
    tbl[3]  = '{32'h80FF_7F01, 2'd2, 3'd5, 32'h0000_80FF};
    tbl[4]  = '{32'h80FF_7F01, 2'd0, 3'd0, 32'h0000_0001};
    tbl[5]  = '{32'h80FF_7F01, 2'd3, 3'd0, 32'hFFFF_FF80};
    tbl[6]  = '{32'h80FF_7F01, 2'd3, 3'd4, 32'h0000_0080};
    tbl[7]  = '{32'h80FF_7F01, 2'd0, 3'd1, 32'h0000_7F01};
    tbl[8]  = '{32'h80FF_7F01, 2'd0, 3'd2, 32'h80FF_7F01};
    tbl[9]  = '{32'h80FF_7F01, 2'd0, 3'd6, 32'h80FF_7F01};
    tbl[10] = '{32'h1234_8001, 2'd2, 3'd1, 32'h0000_1234};
    tbl[11] = '{32'h1234_8001, 2'd0, 3'd7, 32'h1234_8001};

    do_reset();
    check("rst_valid", wb_valid, 1'b0);
    check("rst_allow", allow_in, 1'b1);
    check("rst_dest", me_dest, 5'd0);
    check("rst_fwd", fwd_valid, 1'b0);

    // ALU op passes through in one cycle.
    ex_valid = 1'b1;
    ex_bus   = mk(32'h100, 32'h1234_5678, 3'd0, 1'b0, 1'b1, 5'd7);
    cyc();
    ex_valid = 1'b0;
    @(negedge clk);
    check("alu_valid", wb_valid, 1'b1);
    check("alu_res", wb_res, 32'h1234_5678);
    check("alu_pc", wb_pc, 32'h100);
    check("alu_dest", me_dest, 5'd7);
    check("alu_fwd", fwd_valid, 1'b1);
    check("alu_fwd_data", fwd_data, 32'h1234_5678);

    // Extraction table, data returned the cycle after the load enters.
    for (int i = 0; i < 12; i++) begin
      cyc();
      data_ok  = 1'b0;
      ex_valid = 1'b1;
      ex_bus   = mk(32'h300 + 32'(i * 4), {30'h400, tbl[i].off}, tbl[i].op, 1'b1, 1'b1, 5'd3);
      cyc();
      ex_valid = 1'b0;
      data_ok  = 1'b1;
      rdata    = tbl[i].rdata;
      @(negedge clk);
      check($sformatf("tbl%0d_valid", i), wb_valid, 1'b1);
      check($sformatf("tbl%0d_res", i), wb_res, tbl[i].exp);
    end
    cyc();
    data_ok = 1'b0;

    // Load whose data arrives late: stage holds and blocks EX.
    cyc();
    ex_valid = 1'b1;
    ex_bus   = mk(32'h400, 32'h1001, 3'd0, 1'b1, 1'b1, 5'd9);
    cyc();
    ex_valid = 1'b0;
    @(negedge clk);
    check("late_valid0", wb_valid, 1'b0);
    check("late_allow0", allow_in, 1'b0);
    check("late_fwd0", fwd_valid, 1'b0);
    check("late_dest0", me_dest, 5'd9);
    cyc();
    @(negedge clk);
    check("late_valid1", wb_valid, 1'b0);
    check("late_allow1", allow_in, 1'b0);
    cyc();
    data_ok = 1'b1;
    rdata   = 32'h80FF_7F01;
    @(negedge clk);
    check("late_valid2", wb_valid, 1'b1);
    check("late_res", wb_res, 32'h0000_007F);
    check("late_fwd2", fwd_valid, 1'b1);
    check("late_allow2", allow_in, 1'b1);
    cyc();
    data_ok = 1'b0;
    @(negedge clk);
    check("late_gone", wb_valid, 1'b0);

    // WB stall: returned data must survive in the buffer after rdata changes.
    cyc();
    ex_valid = 1'b1;
    ex_bus   = mk(32'h500, 32'h2000, 3'd2, 1'b1, 1'b1, 5'd4);
    cyc();
    ex_valid = 1'b0;
    wb_allow = 1'b0;
    data_ok  = 1'b1;
    rdata    = 32'hDEAD_BEEF;
    @(negedge clk);
    check("stall_valid0", wb_valid, 1'b1);
    check("stall_res0", wb_res, 32'hDEAD_BEEF);
    check("stall_allow0", allow_in, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      data_ok = 1'b0;
      rdata   = 32'h0;
      @(negedge clk);
      check($sformatf("stall_hold%0d", i), wb_res, 32'hDEAD_BEEF);
      check($sformatf("stall_valid_h%0d", i), wb_valid, 1'b1);
    end
    cyc();
    wb_allow = 1'b1;
    @(negedge clk);
    check("stall_rel_valid", wb_valid, 1'b1);
    check("stall_rel_res", wb_res, 32'hDEAD_BEEF);
    check("stall_rel_allow", allow_in, 1'b1);
    cyc();
    @(negedge clk);
    check("stall_once", wb_valid, 1'b0);

    // Flush during wait: first response is stale and must be dropped.
    cyc();
    ex_valid = 1'b1;
    ex_bus   = mk(32'h200, 32'h3000, 3'd2, 1'b1, 1'b1, 5'd5);
    cyc();
    ex_valid = 1'b0;
    @(negedge clk);
    check("fl_wait", wb_valid, 1'b0);
    cyc();
    flush = 1'b1;
    @(negedge clk);
    check("fl_valid", wb_valid, 1'b0);
    check("fl_allow", allow_in, 1'b0);
    cyc();
    flush    = 1'b0;
    ex_valid = 1'b1;
    ex_bus   = mk(32'h204, 32'h3004, 3'd2, 1'b1, 1'b1, 5'd6);
    @(negedge clk);
    check("fl_empty_allow", allow_in, 1'b1);
    check("fl_empty_valid", wb_valid, 1'b0);
    cyc();
    ex_valid = 1'b0;
    data_ok  = 1'b1;
    rdata    = 32'hAAAA_AAAA;
    @(negedge clk);
    check("fl_stale_valid", wb_valid, 1'b0);
    check("fl_stale_allow", allow_in, 1'b0);
    cyc();
    rdata = 32'h1357_9BDF;
    @(negedge clk);
    check("fl_new_valid", wb_valid, 1'b1);
    check("fl_new_res", wb_res, 32'h1357_9BDF);
    check("fl_new_pc", wb_pc, 32'h204);
    cyc();
    data_ok = 1'b0;

    // Async reset off-edge with a stale response counted and an instruction stalled.
    cyc();
    ex_valid = 1'b1;
    ex_bus   = mk(32'h600, 32'h4000, 3'd2, 1'b1, 1'b1, 5'd2);
    cyc();
    ex_valid = 1'b0;
    flush    = 1'b1;
    cyc();
    flush    = 1'b0;
    ex_valid = 1'b1;
    wb_allow = 1'b0;
    ex_bus   = mk(32'h604, 32'h5555, 3'd0, 1'b0, 1'b1, 5'd12);
    cyc();
    ex_valid = 1'b0;
    @(negedge clk);
    check("ar_pre_valid", wb_valid, 1'b1);
    check("ar_pre_allow", allow_in, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", wb_valid, 1'b0);
    check("ar_fwd", fwd_valid, 1'b0);
    check("ar_allow", allow_in, 1'b1);
    check("ar_dest", me_dest, 5'd0);
    cyc();
    reset    = 1'b0;
    wb_allow = 1'b1;
    ex_valid = 1'b1;
    ex_bus   = mk(32'h700, 32'h6000, 3'd2, 1'b1, 1'b1, 5'd8);
    cyc();
    ex_valid = 1'b0;
    data_ok  = 1'b1;
    rdata    = 32'h2468_ACE0;
    @(negedge clk);
    check("ar_drop_clear_valid", wb_valid, 1'b1);
    check("ar_drop_clear_res", wb_res, 32'h2468_ACE0);

    // Randomized traffic against a transaction-level model.
    do_reset();
    pc_ctr  = 32'h1_0000;
    next_id = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      flush    = ($urandom_range(0, 15) == 0) && (pend.size() <= 2);
      ex_valid = !flush && ($urandom_range(0, 3) != 0);
      wb_allow = ($urandom_range(0, 3) != 0);
      data_ok  = (pend.size() > 0) && ($urandom_range(0, 2) == 0);
      rdata    = data_ok ? pend[0].data : $urandom;
      is_ld    = 1'($urandom_range(0, 1));
      op       = 3'($urandom_range(0, 7));
      alu      = $urandom;
      we       = 1'($urandom_range(0, 1));
      dst      = 5'($urandom_range(0, 31));
      ld_data  = $urandom;
      if (is_ld && (op[1:0] == 2'd1)) alu[0] = 1'b0;
      if (is_ld && (op[1:0] == 2'd2 || op[1:0] == 2'd3) && op != 3'd7) alu[1:0] = 2'b00;
      ex_bus = mk(pc_ctr, alu, op, is_ld, we, dst);
      @(negedge clk);

      exp_ready = (mq.size() == 0) ? 1'b1 :
                  (!mq[0].ld || mq[0].got || (data_ok && pend[0].id == mq[0].id));
      exp_valid = (mq.size() > 0) && exp_ready && !flush;
      exp_allow = (mq.size() == 0) || (exp_ready && wb_allow);
      check("rnd_valid", wb_valid, exp_valid);
      check("rnd_allow", allow_in, exp_allow);
      if (mq.size() > 0) begin
        check("rnd_fwd", fwd_valid, mq[0].we && exp_ready);
        check("rnd_dest", me_dest, mq[0].we ? mq[0].dest : 5'd0);
      end
      if (exp_valid) begin
        check("rnd_pc", wb_pc, mq[0].pc);
        check("rnd_we", wb_we, mq[0].we);
        check("rnd_dst", wb_dst, mq[0].dest);
        check("rnd_res", wb_res, mq[0].res);
      end

      if (data_ok) begin
        if (mq.size() > 0 && mq[0].ld && pend[0].id == mq[0].id) begin
          e     = mq[0];
          e.got = 1'b1;
          mq[0] = e;
        end
        void'(pend.pop_front());
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (exp_valid && wb_allow) void'(mq.pop_front());
        if (ex_valid && exp_allow) begin
          e.pc   = pc_ctr;
          e.we   = we;
          e.dest = dst;
          e.ld   = is_ld;
          e.got  = 1'b0;
          e.id   = next_id;
          e.res  = is_ld ? ref_load(ld_data, alu[1:0], op) : alu;
          mq.push_back(e);
          if (is_ld) begin
            r.id   = next_id;
            r.data = ld_data;
            pend.push_back(r);
          end
          next_id++;
          pc_ctr = pc_ctr + 32'd4;
        end
      end
    end

    cyc();
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
